// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Holds the default configuration constants and the id-width helper used to
// size requester ids throughout the mul_share_* modules.
package mul_share_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_LAT     = 2;

    // Requester id width; a single requester still gets a 1-bit id.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_rr_pick.sv
// Combinational one-hot request picker.
// Default: round-robin, searching ptr+1, ptr+2, ... modulo NUM_REQ.
// With MUL_SHARE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the ptr input is not present.
// Ports:
//   req          per-requester request
//   ptr          index granted last (round-robin build only)
//   en           picker enable; no grant when low
//   grant_c      one-hot grant (or zero)
//   grant_idx_c  index of the granted requester (0 when no grant)
module mul_share_rr_pick
    import mul_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_idx_c
);

    logic [ID_W-1:0] idx;
    logic            found;

    // First asserted request in search order wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        if (en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
                idx = ID_W'(k);
`else
                idx = ID_W'((32'(ptr) + k + 32'd1) % NUM_REQ);
`endif
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    grant_c[idx] = 1'b1;
                    grant_idx_c  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// One pipelined WIDTH x WIDTH unsigned multiplier shared by NUM_REQ requesters.
// Requests arbitrate round-robin (or fixed priority when
// MUL_SHARE_ARB_FIXED_PRIO_EN is defined); results return on a single response
// channel tagged with the requester id. Response backpressure freezes every
// pipeline stage, so results leave strictly in acceptance order.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_data     issuing requester and full 2*WIDTH product
//   busy                any stage holds a valid entry
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    parameter  int unsigned LAT     = DEF_LAT,
    localparam int unsigned ID_W    = id_w(NUM_REQ),
    localparam int unsigned PW      = 2 * WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PW-1:0]            rsp_data,
    output logic                     busy
);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_stage_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [PW-1:0]   prod;
    } prod_stage_t;

    logic               stall;
    logic               pick_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];
    op_stage_t          s1;
    prod_stage_t        s1_prod;

    // Unpack operand buses per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i] = req_a[i*WIDTH +: WIDTH];
        assign op_b[i] = req_b[i*WIDTH +: WIDTH];
    end

    assign stall     = rsp_valid && !rsp_ready;
    assign pick_en   = rst_n && !stall;
    assign req_ready = grant;

`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr;

    // Round-robin pointer: last granted index; reset makes requester 0 first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (|grant) begin
            ptr <= grant_idx;
        end
    end
`endif

    mul_share_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req         (req_valid),
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
        .ptr         (ptr),
`endif
        .en          (pick_en),
        .grant_c     (grant),
        .grant_idx_c (grant_idx)
    );

    // Stage 1: capture the granted operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (!stall) begin
            s1.valid <= |grant;
            s1.id    <= grant_idx;
            s1.a     <= op_a[grant_idx];
            s1.b     <= op_b[grant_idx];
        end
    end

    // Product formed from stage-1 registers.
    always_comb begin
        s1_prod.valid = s1.valid;
        s1_prod.id    = s1.id;
        s1_prod.prod  = PW'(s1.a) * PW'(s1.b);
    end

    if (LAT == 1) begin : g_lat1
        assign rsp_valid = s1_prod.valid;
        assign rsp_id    = s1_prod.id;
        assign rsp_data  = s1_prod.prod;
        assign busy      = s1.valid;
    end else begin : g_latn
        prod_stage_t tail [LAT-1];
        logic        tail_busy;

        // Stages 2..LAT carry the product; all freeze together on stall.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < LAT - 1; i++) begin
                    tail[i] <= '0;
                end
            end else if (!stall) begin
                tail[0] <= s1_prod;
                for (int unsigned i = 1; i < LAT - 1; i++) begin
                    tail[i] <= tail[i-1];
                end
            end
        end

        always_comb begin
            tail_busy = 1'b0;
            for (int unsigned i = 0; i < LAT - 1; i++) begin
                tail_busy = tail_busy | tail[i].valid;
            end
        end

        assign rsp_valid = tail[LAT-2].valid;
        assign rsp_id    = tail[LAT-2].id;
        assign rsp_data  = tail[LAT-2].prod;
        assign busy      = s1.valid | tail_busy;
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb (NUM_REQ=4, WIDTH=8, LAT=2).
// A negedge monitor predicts req_ready from its own arbitration model, pushes
// expected {id, product, timing} on every accept and pops/compares on every
// response handshake. Directed sections cover reset, single op, contention,
// corner operands, backpressure and reset mid-flight.
module tb_mul_share_arb;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_data;
    logic           busy;

    mul_share_arb #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .LAT     (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
        int          stl;
    } sb_t;

    sb_t          sb_q [$];
    logic [N-1:0] acc_mask  = '0;
    int           cyc       = 0;
    int           stall_cnt = 0;
    int           model_ptr = N - 1;

    logic [7:0] op_a [N][16];
    logic [7:0] op_b [N][16];
    int         cnt  [N];
    int         pos  [N];

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p, input logic en);
        logic [N-1:0] g;
        int           j;
        g = '0;
        if (en) begin
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
            for (int k = 0; k < N; k++) begin
                j = k + (p - p);
                if (g == '0 && v[j]) g[j] = 1'b1;
            end
`else
            for (int k = 1; k <= N; k++) begin
                j = (p + k) % N;
                if (g == '0 && v[j]) g[j] = 1'b1;
            end
`endif
        end
        return g;
    endfunction

    // Monitor: arbitration prediction and scoreboard.
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_g;
        logic         st;
        sb_t          e;
        if (!rst_n) begin
            sb_q.delete();
            model_ptr = N - 1;
            acc_mask  = '0;
            check("rdy_in_rst", 32'(req_ready), 32'(0));
        end else begin
            st    = rsp_valid && !rsp_ready;
            exp_g = model_grant(req_valid, model_ptr, !st);
            check("req_ready", 32'(req_ready), 32'(exp_g));
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_extra", 32'(rsp_valid), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_lat", 32'(cyc - e.cyc), 32'(int'(LAT) + stall_cnt - e.stl));
                end
            end
            acc_mask = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    e.id   = 2'(i);
                    e.data = 16'(req_a[i*W +: W]) * 16'(req_b[i*W +: W]);
                    e.cyc  = cyc;
                    e.stl  = stall_cnt;
                    sb_q.push_back(e);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (exp_g[i]) model_ptr = i;
            end
            if (st) stall_cnt++;
            cyc++;
        end
    end

    // Requesters hold valid/operands until accepted, then present their next op.
    task automatic drive_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc_mask[i]) pos[i]++;
            if (pos[i] < cnt[i]) begin
                req_valid[i]     = 1'b1;
                req_a[i*W +: W]  = op_a[i][pos[i]];
                req_b[i*W +: W]  = op_b[i][pos[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic add_op(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i][cnt[i]] = a;
        op_b[i][cnt[i]] = b;
        cnt[i]++;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            pos[i] = 0;
        end
    endtask

    function automatic bit plans_done();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < cnt[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 300 && !(plans_done() && req_valid == '0 && sb_q.size() == 0 && !busy)) begin
            drive_cycle();
            n++;
        end
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        clear_plan();
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        clear_plan();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op: 0x0C * 0x0A from requester 0.
        add_op(0, 8'h0C, 8'h0A);
        drive_cycle();
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h1);
        drive_cycle();
        drive_cycle();
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'(1));
        check("single_id", 32'(rsp_id), 32'(0));
        check("single_data", 32'(rsp_data), 32'h0078);
        wait_idle("single");

        // Full contention: all requesters valid every cycle.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                add_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end
        wait_idle("contend");

        // Corner operands from a single continuous requester.
        add_op(1, 8'hFF, 8'hFF);
        add_op(1, 8'h00, 8'hFF);
        add_op(1, 8'h80, 8'h02);
        drive_cycle();
        drive_cycle();
        drive_cycle();
        @(negedge clk);
        check("corner_ff_ff", 32'(rsp_data), 32'hFE01);
        wait_idle("corner");

        // Backpressure: hold rsp_ready low with responses pending.
        rsp_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                add_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end
        for (int n = 0; n < 20 && !rsp_valid; n++) begin
            drive_cycle();
            @(negedge clk);
        end
        check("bp_seen", 32'(rsp_valid), 32'(1));
        for (int n = 0; n < 5; n++) begin
            drive_cycle();
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'(1));
            check("bp_ready", 32'(req_ready), 32'(0));
            check("bp_busy", 32'(busy), 32'(1));
            check("bp_sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
                check("bp_id", 32'(rsp_id), 32'(sb_q[0].id));
                check("bp_data", 32'(rsp_data), 32'(sb_q[0].data));
            end
        end
        drive_cycle();
        rsp_ready = 1'b1;
        wait_idle("bp");

        // Reset mid-flight: two accepted ops are discarded.
        rsp_ready = 1'b0;
        add_op(0, 8'h11, 8'h22);
        add_op(1, 8'h33, 8'h44);
        drive_cycle();
        drive_cycle();
        drive_cycle();
        rst_n = 1'b0;
        drive_cycle();
        @(negedge clk);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mrst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        clear_plan();
        add_op(3, 8'h05, 8'h07);
        add_op(0, 8'h09, 8'h03);
        drive_cycle();
        @(negedge clk);
        check("mrst_first_grant", 32'(req_ready), 32'h1);
        wait_idle("mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined WIDTH x WIDTH unsigned multiplier between NUM_REQ requesters (e.g. several serial decoders or host channels).
- Round-robin arbitration with a per-requester valid/ready request handshake.
- Single response channel tagged with the requester id; the pipeline freezes under response backpressure.
- Sits between the input decoders and the result/output mux of the multiplier demo design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- LAT, 2, pipeline stages from accepted request to rsp_valid (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  requester that issued the response.
- rsp_data  out  2*WIDTH  unsigned product a*b.
- busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Handshake: a request is accepted in the cycle where req_valid[i] && req_ready[i].
  - The requester must hold valid, a and b stable until accepted.
  - req_ready is combinational from req_valid, the rr pointer and the stall signal.
- stall = rsp_valid && !rsp_ready.
  - While stall is high: all stages hold, req_ready = 0, no pointer update.
- Arbitration: grant goes to the first asserted req_valid searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - On an accepted grant, ptr <= granted index.
  - No request, or stall: ptr unchanged.
  - At most one grant per cycle.
- Pipeline: stage 1 registers a, b, id and valid. The product is formed from stage-1 registers. Stages 2..LAT carry product, id and valid.
  - With LAT=1, the product is formed combinationally from stage-1 registers.
  - rsp_valid/rsp_id/rsp_data come from the last stage.
  - Latency: an accept in cycle N gives rsp_valid in cycle N+LAT when there is no stall.
  - Throughput: 1 result per cycle with no stall.
- Responses leave strictly in acceptance order; none are dropped or duplicated.
- Bubble collapse is not required: a stall freezes every stage, including empty ones.
- Arithmetic: unsigned, full 2*WIDTH result, no truncation. Example: 0xFF*0xFF = 0xFE01.
- Reset (rst_n low at a clk edge):
  - All stage valids = 0, so rsp_valid = 0 and busy = 0.
  - rsp_id = 0, rsp_data = 0.
  - ptr = NUM_REQ-1, so requester 0 wins first.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation: all in-flight entries are discarded without a response. Requesters re-present.
- Boundary cases:
  - A single requester asserting continuously is granted every cycle.
  - When ptr points at the only requesting index, the search wraps back to it and grants it.
  - Simultaneous stall release and a new request: the grant happens in the same cycle rsp_ready rises.

Optional Feature:
- Macro: MUL_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The ptr register is removed, and reset has no ptr value.
- Undefined (default): round-robin as described above.
- Latency and handshake are identical in both modes.

Decomposition:
- Shared package mul_share_pkg:
  - ID_W function/localparam ($clog2 of NUM_REQ, minimum 1).
  - Default WIDTH/LAT constants.
  - Stage struct-like typedef {valid, id, a, b / product}.
- One sub-module, mul_share_rr_pick: combinational one-hot picker with inputs req, ptr and enable; outputs grant and grant index. The FIXED_PRIO variant lives inside it.

Test Plan:
- Single op: req0 valid with a=0x0C, b=0x0A → ready same cycle; LAT=2 cycles later rsp_valid=1, id=0, data=0x0078.
- Full contention: all 4 requesters valid every cycle → grants 0,1,2,3,0,1 on consecutive cycles; responses in the same id order.
- Fixed priority: the same stimulus with MUL_SHARE_ARB_FIXED_PRIO_EN → grants 0,0,0 and higher ids are never granted while req0 is held.
- Backpressure: hold rsp_ready=0 for 5 cycles with a response pending → rsp_valid/id/data stable, req_ready=0, busy=1. Release → the queued results come out back-to-back with none lost.
- Corner values: a=0xFF, b=0xFF → 0xFE01. a=0, b=0xFF → 0x0000. a=0x80, b=0x02 → 0x0100.
- Reset mid-flight: accept 2 requests, assert rst_n=0 one cycle later → rsp_valid=0 and busy=0 after the edge, no stale response after release, next grant goes to requester 0.
